// File: rtl/qtable_wr_sched.sv
// -----------------------------------------------------------------------------
// qtable_wr_sched
// Write scheduler for a Q-table bank. After reset (or a clear request) it
// sweeps zeros into every entry, then arbitrates round-robin between an agent
// update port and a host configuration port. It issues at most one bank
// write per cycle.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_valid/a_addr/a_data      agent request      -> a_ready (combinational)
//   h_valid/h_addr/h_data      host request       -> h_ready (combinational)
//   clr_req                    one-cycle pulse, (re)starts the clear sweep
//   wr_sel/wr_en/wr_data       registered bank write port
//   init_done                  bank cleared and scheduler running
//   err                        one-cycle pulse, accepted address out of range
// -----------------------------------------------------------------------------
module qtable_wr_sched #(
    parameter int DATA_W    = 16,
    parameter int N_ENTRIES = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [3:0]        a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              h_valid,
    input  logic [3:0]        h_addr,
    input  logic [DATA_W-1:0] h_data,
    output logic              h_ready,
    input  logic              clr_req,
    output logic [3:0]        wr_sel,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              init_done,
    output logic              err
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(N_ENTRIES - 1);
    localparam logic [4:0] N_LIM    = 5'(N_ENTRIES);

    state_t            state_r;
    logic [3:0]        count_r;
    logic              rr_last_a_r;   // 1: agent won most recently, host favoured next
    logic              wr_en_r;
    logic [3:0]        wr_sel_r;
    logic [DATA_W-1:0] wr_data_r;
    logic              init_done_r;
    logic              err_r;

    logic              a_gnt_s;
    logic              h_gnt_s;
    logic              xfer_s;
    logic [3:0]        sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              in_range_s;
    logic [3:0]        sweep_idx_s;

    // Round-robin grant; only the RUN state ever grants.
    always_comb begin
        a_gnt_s = 1'b0;
        h_gnt_s = 1'b0;
        if (state_r == ST_RUN) begin
            if (a_valid && h_valid) begin
                if (rr_last_a_r) begin
                    h_gnt_s = 1'b1;
                end else begin
                    a_gnt_s = 1'b1;
                end
            end else if (a_valid) begin
                a_gnt_s = 1'b1;
            end else if (h_valid) begin
                h_gnt_s = 1'b1;
            end else begin
                a_gnt_s = 1'b0;
                h_gnt_s = 1'b0;
            end
        end else begin
            a_gnt_s = 1'b0;
            h_gnt_s = 1'b0;
        end
    end

    // Winner's payload mux and range check.
    always_comb begin
        xfer_s = a_gnt_s | h_gnt_s;
        if (a_gnt_s) begin
            sel_addr_s = a_addr;
            sel_data_s = a_data;
        end else begin
            sel_addr_s = h_addr;
            sel_data_s = h_data;
        end
        in_range_s = ({1'b0, sel_addr_s} < N_LIM);
    end

    // A clear request arriving mid-sweep makes this cycle write entry 0 again.
    always_comb begin
        if (clr_req) begin
            sweep_idx_s = 4'd0;
        end else begin
            sweep_idx_s = count_r;
        end
    end

    // Scheduler state, sweep counter, round-robin pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_CLEAR;
            count_r     <= 4'd0;
            rr_last_a_r <= 1'b0;
            wr_en_r     <= 1'b0;
            wr_sel_r    <= 4'd0;
            wr_data_r   <= '0;
            init_done_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    wr_en_r     <= 1'b1;
                    wr_sel_r    <= sweep_idx_s;
                    wr_data_r   <= '0;
                    err_r       <= 1'b0;
                    init_done_r <= 1'b0;
                    // The >= guard keeps the counter within 0..N_ENTRIES-1.
                    if (sweep_idx_s >= LAST_IDX) begin
                        state_r <= ST_RUN;
                        count_r <= 4'd0;
                    end else begin
                        state_r <= ST_CLEAR;
                        count_r <= sweep_idx_s + 4'd1;
                    end
                end
                ST_RUN: begin
                    if (xfer_s) begin
                        rr_last_a_r <= a_gnt_s;
                        if (in_range_s) begin
                            wr_en_r   <= 1'b1;
                            wr_sel_r  <= sel_addr_s;
                            wr_data_r <= sel_data_s;
                            err_r     <= 1'b0;
                        end else begin
                            // Out-of-range request is consumed without a write.
                            wr_en_r <= 1'b0;
                            err_r   <= 1'b1;
                        end
                    end else begin
                        wr_en_r <= 1'b0;
                        err_r   <= 1'b0;
                    end
                    // The grant above still completes; the sweep starts next cycle.
                    if (clr_req) begin
                        state_r     <= ST_CLEAR;
                        count_r     <= 4'd0;
                        init_done_r <= 1'b0;
                    end else begin
                        state_r     <= ST_RUN;
                        init_done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_CLEAR;
                    count_r     <= 4'd0;
                    wr_en_r     <= 1'b0;
                    err_r       <= 1'b0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign a_ready   = a_gnt_s;
    assign h_ready   = h_gnt_s;
    assign wr_en     = wr_en_r;
    assign wr_sel    = wr_sel_r;
    assign wr_data   = wr_data_r;
    assign init_done = init_done_r;
    assign err       = err_r;

endmodule

// File: doc/qtable_wr_sched.md
QTABLE_WR_SCHED -- requirements
Module: qtable_wr_sched

Interface
REQ-001 Parameter DATA_W, default 16, width of one Q-table entry.
REQ-002 Parameter N_ENTRIES, default 15, number of bank entries; legal write addresses 0..N_ENTRIES-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 a_valid  input  1  agent update request valid.
REQ-006 a_addr  input  4  agent target entry index.
REQ-007 a_data  input  DATA_W  agent write data.
REQ-008 a_ready  output  1  agent request accepted this cycle.
REQ-009 h_valid  input  1  host config request valid.
REQ-010 h_addr  input  4  host target entry index.
REQ-011 h_data  input  DATA_W  host write data.
REQ-012 h_ready  output  1  host request accepted this cycle.
REQ-013 clr_req  input  1  single-cycle pulse; requests full-bank clear.
REQ-014 wr_sel  output  4  entry index driven to the bank's 4-bit enable decoder.
REQ-015 wr_en  output  1  bank write strobe, one cycle per write.
REQ-016 wr_data  output  DATA_W  bank write data.
REQ-017 init_done  output  1  high when bank is cleared and scheduler is in RUN.
REQ-018 err  output  1  one-cycle pulse on accepted out-of-range address.

Function
REQ-019 States SHALL be CLEAR and RUN only.
REQ-020 CLEAR SHALL write zero to entries 0..N_ENTRIES-1 in ascending order, one per cycle: wr_en=1, wr_sel=count, wr_data=0, for exactly N_ENTRIES cycles.
REQ-021 After the write of entry N_ENTRIES-1, state SHALL go to RUN and init_done SHALL rise the following cycle.
REQ-022 In CLEAR, a_ready, h_ready and init_done SHALL be 0; incoming valids are ignored and not lost (requester holds).
REQ-023 In RUN, ready SHALL be combinational from state, valids and rr pointer: exactly one of a_ready/h_ready high when any valid is high, both low otherwise.
REQ-024 Round-robin: single valid wins; both valid, the requester not granted most recently wins; pointer resets to favour agent.
REQ-025 Transfer occurs when valid and ready both high; the pointer updates to the winner on that edge.
REQ-026 Accepted in-range transfer SHALL produce wr_en=1 with registered wr_sel=addr and wr_data=data on the next cycle (latency 1); back-to-back grants sustain one write per cycle.
REQ-027 Accepted address >= N_ENTRIES SHALL be consumed (ready high), produce no wr_en, and pulse err for one cycle at latency 1.
REQ-028 When no transfer occurs, wr_en SHALL be 0; wr_sel and wr_data hold last value.
REQ-029 Requesters SHALL keep valid, addr, data stable until accepted; the block does not check this.
REQ-030 clr_req in RUN: the cycle clr_req is high still grants normally; state SHALL enter CLEAR next cycle with count=0, after any write issued from that grant.
REQ-031 clr_req during CLEAR SHALL restart the sweep from entry 0.
REQ-032 Sweep counter SHALL be 4 bits and never exceed N_ENTRIES-1.

Reset
REQ-033 rst_n low SHALL immediately force: state CLEAR, count 0, wr_en 0, wr_sel 0, wr_data 0, a_ready 0, h_ready 0, init_done 0, err 0, rr pointer agent.
REQ-034 On rst_n release the sweep SHALL start on the first rising edge; reset asserted mid-sweep or mid-write aborts it with no partial strobe.

Verification
REQ-035 Release reset -> wr_en high 15 consecutive cycles, wr_sel 0..14, wr_data 0; init_done=1 on cycle 16.
REQ-036 RUN, a_valid with a_addr=5, a_data=0x00A3 -> a_ready same cycle; next cycle wr_en=1, wr_sel=5, wr_data=0x00A3.
REQ-037 RUN, a_valid and h_valid held 4 cycles -> grants alternate A,H,A,H; four consecutive wr_en pulses with matching addr/data.
REQ-038 RUN, h_addr=15 -> h_ready=1, next cycle err=1, wr_en=0.
REQ-039 clr_req pulse with a_valid (addr 3) -> write to 3 next cycle, then 15-cycle sweep, init_done low throughout, a_ready low.
REQ-040 rst_n pulsed low at sweep entry 7 -> all outputs 0 asynchronously; sweep restarts from 0 after release.
